// File: rtl/ifu_thrwm_ctl.sv
// ---------------------------------------------------------------------------
// ifu_thrwm_ctl
//
// Thread wait-mask and thread-state controller for the four threads of one
// core. Each thread carries three kinds of wait condition:
//   - imiss    : an instruction miss is outstanding
//   - stbwait  : the store buffer is full
//   - other    : a long-latency multiply, divide or FP op is outstanding
// A thread whose masks are all clear is eligible to run. One thread FSM per
// thread tracks IDLE / WAIT / RDY / RUN (plus SPEC_RDY / SPEC_RUN when
// speculative wake-up is built in).
//
// Build option:
//   IFU_THRWM_SPEC_EN  When defined, a waiting thread may wake speculatively
//                      (SPEC_RDY / SPEC_RUN). It is later confirmed
//                      (spec_cfm) or killed (spec_kill -> WAIT on imiss).
//                      When undefined, spec_ok/spec_cfm/spec_kill are
//                      ignored and WAIT always exits straight to RDY.
//
// Ports:
//   clk, rst_l                  clock, asynchronous active-low reset
//   thr_start / thr_stop        per-thread start (IDLE->RDY) / stop (->IDLE)
//   sel_thr                     one-hot scheduler pick
//   switch_out                  running thread yields (RUN->RDY)
//   imiss_set/clr, stb_set/clr  wait-mask set/clear events
//   mul/div/fp _issue/_done     long-latency unit launch / return
//   spec_ok, spec_cfm, spec_kill  speculative wake, confirm, kill
//   thr_state0..3               registered thread states (5-bit encodings)
//   wm_imiss, wm_stbwait, wm_other  registered wait masks
//   mul_wait, div_wait, fp_wait     registered per-unit wait bits
//   *_wait_nxt                  combinational next values of the unit bits
//   completion                  one-cycle pulse after a wake to RDY/RUN
//   rdy_vec                     thread is RDY or SPEC_RDY
// ---------------------------------------------------------------------------
module ifu_thrwm_ctl (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] thr_start,
  input  logic [3:0] thr_stop,
  input  logic [3:0] sel_thr,
  input  logic [3:0] switch_out,
  input  logic [3:0] imiss_set,
  input  logic [3:0] imiss_clr,
  input  logic [3:0] stb_set,
  input  logic [3:0] stb_clr,
  input  logic [3:0] mul_issue,
  input  logic [3:0] mul_done,
  input  logic [3:0] div_issue,
  input  logic [3:0] div_done,
  input  logic [3:0] fp_issue,
  input  logic [3:0] fp_done,
  input  logic [3:0] spec_ok,
  input  logic [3:0] spec_cfm,
  input  logic [3:0] spec_kill,
  output logic [4:0] thr_state0,
  output logic [4:0] thr_state1,
  output logic [4:0] thr_state2,
  output logic [4:0] thr_state3,
  output logic [3:0] wm_imiss,
  output logic [3:0] wm_stbwait,
  output logic [3:0] wm_other,
  output logic [3:0] mul_wait,
  output logic [3:0] div_wait,
  output logic [3:0] fp_wait,
  output logic [3:0] mul_wait_nxt,
  output logic [3:0] div_wait_nxt,
  output logic [3:0] fp_wait_nxt,
  output logic [3:0] completion,
  output logic [3:0] rdy_vec
);

  typedef enum logic [4:0] {
    THR_IDLE     = 5'b00000,
    THR_WAIT     = 5'b00001,
    THR_RDY      = 5'b11001,
    THR_SPEC_RDY = 5'b10011,
    THR_RUN      = 5'b00101,
    THR_SPEC_RUN = 5'b00111
  } thr_state_e;

  // Registered masks and pulses
  logic [3:0] wm_imiss_q, wm_stbwait_q, wm_other_q;
  logic [3:0] mul_wait_q, div_wait_q, fp_wait_q;
  logic [3:0] completion_q;

  // Next-state values
  logic [3:0] wm_imiss_d, wm_stbwait_d, wm_other_d;
  logic [3:0] mul_wait_d, div_wait_d, fp_wait_d;
  logic [3:0] completion_d;

  // Per-thread state summaries gathered from the thread FSMs
  logic [19:0] state_flat;
  logic [3:0]  idle_vec;
  logic [3:0]  selectable_vec;
  logic [3:0]  kill_set;
  logic [3:0]  any_nxt;
  logic [3:0]  live_vec;

  // Speculation inputs after build-option gating
  logic [3:0]  spec_ok_g;
  logic [3:0]  spec_cfm_g;
  logic [3:0]  spec_kill_g;

  logic        sel_onehot;
  logic        sel_valid;

`ifdef IFU_THRWM_SPEC_EN
  assign spec_ok_g   = spec_ok;
  assign spec_cfm_g  = spec_cfm;
  assign spec_kill_g = spec_kill;
`else
  assign spec_ok_g   = 4'b0000;
  assign spec_cfm_g  = 4'b0000;
  assign spec_kill_g = 4'b0000;
  // Speculation inputs have no function in this build.
  logic unused_spec;
  assign unused_spec = ^{spec_ok, spec_cfm, spec_kill};
`endif

  // -------------------------------------------------------------------------
  // Wait masks. Set events are dropped for IDLE threads so an idle thread
  // can never hold a mask bit; stop wipes every bit of its thread.
  // A killed speculation re-arms the imiss mask so the thread refetches.
  // -------------------------------------------------------------------------
  assign live_vec = ~idle_vec;

  assign wm_imiss_d   = ~thr_stop & ((imiss_set & live_vec) | (wm_imiss_q & ~imiss_clr)
                                     | kill_set);
  assign wm_stbwait_d = ~thr_stop & ((stb_set & live_vec) | (wm_stbwait_q & ~stb_clr));
  assign mul_wait_d   = ~thr_stop & ((mul_issue & live_vec) | (mul_wait_q & ~mul_done));
  assign div_wait_d   = ~thr_stop & ((div_issue & live_vec) | (div_wait_q & ~div_done));
  assign fp_wait_d    = ~thr_stop & ((fp_issue & live_vec) | (fp_wait_q & ~fp_done));
  assign wm_other_d   = mul_wait_d | div_wait_d | fp_wait_d;

  assign any_nxt      = wm_imiss_d | wm_stbwait_d | wm_other_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wm_imiss_q   <= 4'b0000;
      wm_stbwait_q <= 4'b0000;
      wm_other_q   <= 4'b0000;
      mul_wait_q   <= 4'b0000;
      div_wait_q   <= 4'b0000;
      fp_wait_q    <= 4'b0000;
      completion_q <= 4'b0000;
    end else begin
      wm_imiss_q   <= wm_imiss_d;
      wm_stbwait_q <= wm_stbwait_d;
      wm_other_q   <= wm_other_d;
      mul_wait_q   <= mul_wait_d;
      div_wait_q   <= div_wait_d;
      fp_wait_q    <= fp_wait_d;
      completion_q <= completion_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scheduler pick. A pick only counts when it is one-hot and lands on a
  // thread that can actually start running; otherwise nothing moves.
  // -------------------------------------------------------------------------
  assign sel_onehot = (sel_thr != 4'b0000) && ((sel_thr & (sel_thr - 4'b0001)) == 4'b0000);
  assign sel_valid  = sel_onehot && ((sel_thr & selectable_vec) != 4'b0000);

  // -------------------------------------------------------------------------
  // Thread FSMs
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_thr
    thr_state_e state_q;
    thr_state_e state_d;
    logic       sel_mine;
    logic       sel_other;
    logic       is_spec;
    logic       comp_d;

    assign sel_mine  = sel_valid & sel_thr[gi];
    // Another thread was granted: whoever is running here must step aside.
    assign sel_other = sel_valid & ~sel_thr[gi];
    assign is_spec   = (state_q == THR_SPEC_RDY) || (state_q == THR_SPEC_RUN);

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        state_q <= THR_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      comp_d  = 1'b0;
      if (thr_stop[gi]) begin
        state_d = THR_IDLE;
      end else if (state_q == THR_IDLE) begin
        if (thr_start[gi]) begin
          state_d = THR_RDY;
        end
      end else if (any_nxt[gi]) begin
        // Also covers spec_kill: it arms the imiss mask, so any_nxt is set.
        state_d = THR_WAIT;
      end else begin
        case (state_q)
          THR_WAIT: begin
            state_d = spec_ok_g[gi] ? THR_SPEC_RDY : THR_RDY;
          end
          THR_SPEC_RDY: begin
            if (sel_mine) begin
              state_d = THR_SPEC_RUN;
            end else if (spec_cfm_g[gi]) begin
              state_d = THR_RDY;
            end
          end
          THR_SPEC_RUN: begin
            // Being displaced and confirmed together lands in plain RDY.
            if (sel_other) begin
              state_d = spec_cfm_g[gi] ? THR_RDY : THR_SPEC_RDY;
            end else if (spec_cfm_g[gi]) begin
              state_d = THR_RUN;
            end
          end
          THR_RDY: begin
            if (sel_mine) begin
              state_d = THR_RUN;
            end
          end
          THR_RUN: begin
            if (sel_other || switch_out[gi]) begin
              state_d = THR_RDY;
            end
          end
          default: begin
            state_d = THR_IDLE;
          end
        endcase
      end

      // Wake-up from WAIT, or confirmation of a speculative wake.
      comp_d = ((state_q == THR_WAIT) && (state_d == THR_RDY)) ||
               (is_spec && ((state_d == THR_RDY) || (state_d == THR_RUN)));
    end

    assign state_flat[gi*5 +: 5] = state_q;
    assign idle_vec[gi]          = (state_q == THR_IDLE);
    assign selectable_vec[gi]    = (state_q == THR_RDY) || (state_q == THR_SPEC_RDY);
    assign kill_set[gi]          = spec_kill_g[gi] & is_spec;
    assign completion_d[gi]      = comp_d;

    // A thread waits exactly when it holds a mask bit.
    a_wait_iff_mask: assert property (@(posedge clk) disable iff (!rst_l)
      (state_q == THR_WAIT) == (wm_imiss_q[gi] | wm_stbwait_q[gi] | wm_other_q[gi]));
  end

  a_other_is_or: assert property (@(posedge clk) disable iff (!rst_l)
    wm_other_q == (mul_wait_q | div_wait_q | fp_wait_q));

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign thr_state0   = state_flat[4:0];
  assign thr_state1   = state_flat[9:5];
  assign thr_state2   = state_flat[14:10];
  assign thr_state3   = state_flat[19:15];

  assign wm_imiss     = wm_imiss_q;
  assign wm_stbwait   = wm_stbwait_q;
  assign wm_other     = wm_other_q;
  assign mul_wait     = mul_wait_q;
  assign div_wait     = div_wait_q;
  assign fp_wait      = fp_wait_q;

  assign mul_wait_nxt = mul_wait_d;
  assign div_wait_nxt = div_wait_d;
  assign fp_wait_nxt  = fp_wait_d;

  assign completion   = completion_q;
  assign rdy_vec      = selectable_vec;

endmodule

// File: tb/tb_ifu_thrwm_ctl.sv
// ---------------------------------------------------------------------------
// tb_ifu_thrwm_ctl
//
// Directed scenarios for each feature, followed by randomized traffic
// compared against a behavioural model of the thread controller.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ifu_thrwm_ctl;

  localparam logic [4:0] S_IDLE     = 5'b00000;
  localparam logic [4:0] S_WAIT     = 5'b00001;
  localparam logic [4:0] S_RDY      = 5'b11001;
  localparam logic [4:0] S_SPEC_RDY = 5'b10011;
  localparam logic [4:0] S_RUN      = 5'b00101;
  localparam logic [4:0] S_SPEC_RUN = 5'b00111;

`ifdef IFU_THRWM_SPEC_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [3:0] thr_start, thr_stop, sel_thr, switch_out;
  logic [3:0] imiss_set, imiss_clr, stb_set, stb_clr;
  logic [3:0] mul_issue, mul_done, div_issue, div_done, fp_issue, fp_done;
  logic [3:0] spec_ok, spec_cfm, spec_kill;
  logic [4:0] thr_state0, thr_state1, thr_state2, thr_state3;
  logic [3:0] wm_imiss, wm_stbwait, wm_other, mul_wait, div_wait, fp_wait;
  logic [3:0] mul_wait_nxt, div_wait_nxt, fp_wait_nxt, completion, rdy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_thrwm_ctl dut (
    .clk(clk), .rst_l(rst_l),
    .thr_start(thr_start), .thr_stop(thr_stop), .sel_thr(sel_thr), .switch_out(switch_out),
    .imiss_set(imiss_set), .imiss_clr(imiss_clr), .stb_set(stb_set), .stb_clr(stb_clr),
    .mul_issue(mul_issue), .mul_done(mul_done), .div_issue(div_issue), .div_done(div_done),
    .fp_issue(fp_issue), .fp_done(fp_done),
    .spec_ok(spec_ok), .spec_cfm(spec_cfm), .spec_kill(spec_kill),
    .thr_state0(thr_state0), .thr_state1(thr_state1), .thr_state2(thr_state2),
    .thr_state3(thr_state3),
    .wm_imiss(wm_imiss), .wm_stbwait(wm_stbwait), .wm_other(wm_other),
    .mul_wait(mul_wait), .div_wait(div_wait), .fp_wait(fp_wait),
    .mul_wait_nxt(mul_wait_nxt), .div_wait_nxt(div_wait_nxt), .fp_wait_nxt(fp_wait_nxt),
    .completion(completion), .rdy_vec(rdy_vec)
  );

  logic [4:0] dut_st [4];
  always_comb begin
    dut_st[0] = thr_state0;
    dut_st[1] = thr_state1;
    dut_st[2] = thr_state2;
    dut_st[3] = thr_state3;
  end

  // ---------------- behavioural model ----------------
  logic [4:0] m_st [4];
  logic [3:0] m_imiss, m_stb, m_mul, m_div, m_fp, m_comp;
  logic [4:0] n_st [4];
  logic [3:0] n_imiss, n_stb, n_mul, n_div, n_fp, n_comp;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_st[t] = S_IDLE;
    m_imiss = '0; m_stb = '0; m_mul = '0; m_div = '0; m_fp = '0; m_comp = '0;
  endtask

  // Next model state from the current model and the driven inputs.
  task automatic model_next();
    int  pick;
    bit  pick_ok;
    pick = -1;
    pick_ok = 1'b0;
    if ($countones(sel_thr) == 1)
      for (int t = 0; t < 4; t++) if (sel_thr[t]) pick = t;
    if (pick >= 0) pick_ok = (m_st[pick] == S_RDY) || (m_st[pick] == S_SPEC_RDY);
    for (int t = 0; t < 4; t++) begin
      bit live, was_spec, kill, waiting, cfm;
      live     = (m_st[t] != S_IDLE);
      was_spec = (m_st[t] == S_SPEC_RDY) || (m_st[t] == S_SPEC_RUN);
      kill     = SPEC && spec_kill[t] && was_spec;
      cfm      = SPEC && spec_cfm[t];
      if (thr_stop[t]) begin
        n_imiss[t] = 0; n_stb[t] = 0; n_mul[t] = 0; n_div[t] = 0; n_fp[t] = 0;
        n_st[t] = S_IDLE;
      end else begin
        n_imiss[t] = (live && imiss_set[t]) || (m_imiss[t] && !imiss_clr[t]) || kill;
        n_stb[t]   = (live && stb_set[t])   || (m_stb[t]   && !stb_clr[t]);
        n_mul[t]   = (live && mul_issue[t]) || (m_mul[t]   && !mul_done[t]);
        n_div[t]   = (live && div_issue[t]) || (m_div[t]   && !div_done[t]);
        n_fp[t]    = (live && fp_issue[t])  || (m_fp[t]    && !fp_done[t]);
        waiting    = n_imiss[t] | n_stb[t] | n_mul[t] | n_div[t] | n_fp[t];
        n_st[t]    = m_st[t];
        if (!live)
          n_st[t] = thr_start[t] ? S_RDY : S_IDLE;
        else if (waiting)
          n_st[t] = S_WAIT;
        else if (m_st[t] == S_WAIT)
          n_st[t] = (SPEC && spec_ok[t]) ? S_SPEC_RDY : S_RDY;
        else if (pick_ok && pick == t)
          n_st[t] = (m_st[t] == S_RDY) ? S_RUN : S_SPEC_RUN;
        else if (pick_ok && m_st[t] == S_RUN)
          n_st[t] = S_RDY;
        else if (pick_ok && m_st[t] == S_SPEC_RUN)
          n_st[t] = cfm ? S_RDY : S_SPEC_RDY;
        else if (m_st[t] == S_SPEC_RDY && cfm)
          n_st[t] = S_RDY;
        else if (m_st[t] == S_SPEC_RUN && cfm)
          n_st[t] = S_RUN;
        else if (m_st[t] == S_RUN && switch_out[t])
          n_st[t] = S_RDY;
      end
      n_comp[t] = ((m_st[t] == S_WAIT) && (n_st[t] == S_RDY)) ||
                  (was_spec && (n_st[t] == S_RDY || n_st[t] == S_RUN));
    end
  endtask

  task automatic model_commit();
    for (int t = 0; t < 4; t++) m_st[t] = n_st[t];
    m_imiss = n_imiss; m_stb = n_stb; m_mul = n_mul; m_div = n_div; m_fp = n_fp;
    m_comp = n_comp;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    thr_start = '0; thr_stop = '0; sel_thr = '0; switch_out = '0;
    imiss_set = '0; imiss_clr = '0; stb_set = '0; stb_clr = '0;
    mul_issue = '0; mul_done = '0; div_issue = '0; div_done = '0;
    fp_issue = '0; fp_done = '0; spec_ok = '0; spec_cfm = '0; spec_kill = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rbits(int pct);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({thr_state0, thr_state1, thr_state2, thr_state3} !== 20'd0) begin
      errors++;
      $display("FAIL reset_states: got %h %h %h %h want 00 00 00 00",
               thr_state0, thr_state1, thr_state2, thr_state3);
    end
    checks++;
    if ({wm_imiss, wm_stbwait, wm_other, mul_wait, div_wait, fp_wait} !== 24'd0) begin
      errors++;
      $display("FAIL reset_masks: got %b %b %b %b %b %b want all 0",
               wm_imiss, wm_stbwait, wm_other, mul_wait, div_wait, fp_wait);
    end
    checks++;
    if ({completion, rdy_vec} !== 8'd0) begin
      errors++;
      $display("FAIL reset_comp_rdy: got comp=%b rdy=%b want 0000 0000", completion, rdy_vec);
    end
    rst_l = 1'b1;
    step();
    checks++;
    if (thr_state0 !== S_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", thr_state0, S_IDLE);
    end
    $display("test_reset done");
  endtask

  task automatic test_start();
    thr_start = 4'b0101;
    step(); clr_in();
    checks++;
    if ({thr_state0, thr_state1, thr_state2, thr_state3} !== {S_RDY, S_IDLE, S_RDY, S_IDLE}) begin
      errors++;
      $display("FAIL start_states: got %b %b %b %b want %b %b %b %b", thr_state0, thr_state1,
               thr_state2, thr_state3, S_RDY, S_IDLE, S_RDY, S_IDLE);
    end
    checks++;
    if (rdy_vec !== 4'b0101) begin
      errors++;
      $display("FAIL start_rdy_vec: got %b want 0101", rdy_vec);
    end
    $display("test_start done");
  endtask

  task automatic test_mul_wait();
    thr_start = 4'b0010; step(); clr_in();
    sel_thr = 4'b0010; step(); clr_in();
    checks++;
    if (thr_state1 !== S_RUN) begin
      errors++;
      $display("FAIL t1_run: got %b want %b", thr_state1, S_RUN);
    end
    mul_issue = 4'b0010;
    #1;
    checks++;
    if (mul_wait_nxt[1] !== 1'b1) begin
      errors++;
      $display("FAIL mul_wait_nxt_set: got %b want 1", mul_wait_nxt[1]);
    end
    step(); clr_in();
    checks++;
    if ({mul_wait[1], wm_other[1], thr_state1} !== {1'b1, 1'b1, S_WAIT}) begin
      errors++;
      $display("FAIL mul_wait_reg: got mul=%b other=%b st=%b want 1 1 %b",
               mul_wait[1], wm_other[1], thr_state1, S_WAIT);
    end
    step(); step();
    mul_done = 4'b0010;
    #1;
    checks++;
    if (mul_wait_nxt[1] !== 1'b0) begin
      errors++;
      $display("FAIL mul_wait_nxt_clr: got %b want 0", mul_wait_nxt[1]);
    end
    step(); clr_in();
    checks++;
    if ({thr_state1, completion[1], mul_wait[1]} !== {S_RDY, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_done_wake: got st=%b comp=%b mul=%b want %b 1 0",
               thr_state1, completion[1], mul_wait[1], S_RDY);
    end
    step();
    checks++;
    if (completion !== 4'b0000) begin
      errors++;
      $display("FAIL comp_one_cycle: got %b want 0000", completion);
    end
    $display("test_mul_wait done");
  endtask

  task automatic test_overlap();
    imiss_set = 4'b0001; stb_set = 4'b0001;
    step(); clr_in();
    imiss_clr = 4'b0001;
    step(); clr_in();
    checks++;
    if ({thr_state0, wm_stbwait[0], wm_imiss[0]} !== {S_WAIT, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL overlap_partial: got st=%b stb=%b im=%b want %b 1 0",
               thr_state0, wm_stbwait[0], wm_imiss[0], S_WAIT);
    end
    stb_clr = 4'b0001;
    step(); clr_in();
    checks++;
    if ({thr_state0, completion[0]} !== {S_RDY, 1'b1}) begin
      errors++;
      $display("FAIL overlap_wake: got st=%b comp=%b want %b 1", thr_state0, completion[0], S_RDY);
    end
    imiss_set = 4'b0100; imiss_clr = 4'b0100;
    step(); clr_in();
    checks++;
    if ({wm_imiss[2], thr_state2} !== {1'b1, S_WAIT}) begin
      errors++;
      $display("FAIL set_wins: got im=%b st=%b want 1 %b", wm_imiss[2], thr_state2, S_WAIT);
    end
    imiss_clr = 4'b0100;
    step(); clr_in();
    $display("test_overlap done");
  endtask

  task automatic test_scheduler();
    sel_thr = 4'b0001; step(); clr_in();
    sel_thr = 4'b0100; step(); clr_in();
    checks++;
    if ({thr_state0, thr_state2} !== {S_RDY, S_RUN}) begin
      errors++;
      $display("FAIL sched_swap: got t0=%b t2=%b want %b %b", thr_state0, thr_state2, S_RDY, S_RUN);
    end
    sel_thr = 4'b0011; step(); clr_in();
    checks++;
    if ({thr_state0, thr_state1, thr_state2} !== {S_RDY, S_RDY, S_RUN}) begin
      errors++;
      $display("FAIL sched_not_onehot: got %b %b %b want %b %b %b",
               thr_state0, thr_state1, thr_state2, S_RDY, S_RDY, S_RUN);
    end
    sel_thr = 4'b0100; step(); clr_in();
    checks++;
    if (thr_state2 !== S_RUN) begin
      errors++;
      $display("FAIL sched_sel_running: got %b want %b", thr_state2, S_RUN);
    end
    switch_out = 4'b0100; step(); clr_in();
    checks++;
    if ({thr_state2, rdy_vec} !== {S_RDY, 4'b0111}) begin
      errors++;
      $display("FAIL switch_out: got st=%b rdy=%b want %b 0111", thr_state2, rdy_vec, S_RDY);
    end
    $display("test_scheduler done");
  endtask

  task automatic test_spec();
    logic [4:0] exp_st;
    thr_start = 4'b1000; step(); clr_in();
    fp_issue = 4'b1000; step(); clr_in();
    checks++;
    if ({thr_state3, fp_wait[3]} !== {S_WAIT, 1'b1}) begin
      errors++;
      $display("FAIL fp_wait: got st=%b fp=%b want %b 1", thr_state3, fp_wait[3], S_WAIT);
    end
    fp_done = 4'b1000; spec_ok = 4'b1000;
    step(); clr_in();
    exp_st = SPEC ? S_SPEC_RDY : S_RDY;
    checks++;
    if ({thr_state3, completion[3], rdy_vec[3]} !== {exp_st, !SPEC, 1'b1}) begin
      errors++;
      $display("FAIL spec_wake: got st=%b comp=%b rdy=%b want %b %b 1",
               thr_state3, completion[3], rdy_vec[3], exp_st, !SPEC);
    end
    sel_thr = 4'b1000; step(); clr_in();
    exp_st = SPEC ? S_SPEC_RUN : S_RUN;
    checks++;
    if (thr_state3 !== exp_st) begin
      errors++;
      $display("FAIL spec_sel: got %b want %b", thr_state3, exp_st);
    end
    spec_kill = 4'b1000; step(); clr_in();
    exp_st = SPEC ? S_WAIT : S_RUN;
    checks++;
    if ({thr_state3, wm_imiss[3]} !== {exp_st, SPEC}) begin
      errors++;
      $display("FAIL spec_kill: got st=%b im=%b want %b %b", thr_state3, wm_imiss[3], exp_st, SPEC);
    end
    imiss_clr = 4'b1000; switch_out = 4'b1000; step(); clr_in();
    checks++;
    if (thr_state3 !== S_RDY) begin
      errors++;
      $display("FAIL spec_recover: got %b want %b", thr_state3, S_RDY);
    end
    $display("test_spec done");
  endtask

  task automatic test_stop();
    div_issue = 4'b0010; imiss_set = 4'b0010; step(); clr_in();
    checks++;
    if ({thr_state1, div_wait[1]} !== {S_WAIT, 1'b1}) begin
      errors++;
      $display("FAIL div_wait: got st=%b div=%b want %b 1", thr_state1, div_wait[1], S_WAIT);
    end
    thr_stop = 4'b0010; stb_set = 4'b0010; div_issue = 4'b0010;
    #1;
    checks++;
    if (div_wait_nxt[1] !== 1'b0) begin
      errors++;
      $display("FAIL stop_nxt: got %b want 0", div_wait_nxt[1]);
    end
    step(); clr_in();
    checks++;
    if ({thr_state1, wm_imiss[1], wm_stbwait[1], wm_other[1], div_wait[1]} !=={S_IDLE, 4'b0000})
    begin
      errors++;
      $display("FAIL stop_clear: got st=%b im=%b stb=%b oth=%b div=%b want %b 0 0 0 0", thr_state1,
               wm_imiss[1], wm_stbwait[1], wm_other[1], div_wait[1], S_IDLE);
    end
    imiss_set = 4'b0010; step(); clr_in();
    checks++;
    if ({thr_state1, wm_imiss[1]} !== {S_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL idle_ignores_set: got st=%b im=%b want %b 0", thr_state1, wm_imiss[1], S_IDLE);
    end
    $display("test_stop done");
  endtask

  task automatic test_async_reset();
    imiss_set = 4'b0001; step(); clr_in();
    checks++;
    if (thr_state0 !== S_WAIT) begin
      errors++;
      $display("FAIL pre_reset_wait: got %b want %b", thr_state0, S_WAIT);
    end
    #3;
    rst_l = 1'b0;
    #1;
    checks++;
    if ({thr_state0, thr_state1, thr_state2, thr_state3, wm_imiss, wm_stbwait, wm_other,
         mul_wait, div_wait, fp_wait, completion, rdy_vec} !== 52'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%h %h %h %h im=%b rdy=%b want all 0",
               thr_state0, thr_state1, thr_state2, thr_state3, wm_imiss, rdy_vec);
    end
    step();
    rst_l = 1'b1;
    step();
    checks++;
    if ({thr_state0, wm_imiss} !== {S_IDLE, 4'b0000}) begin
      errors++;
      $display("FAIL post_reset: got st=%b im=%b want %b 0000", thr_state0, wm_imiss, S_IDLE);
    end
    $display("test_async_reset done");
  endtask

  // ---------------- randomized traffic vs model ----------------
  task automatic test_random();
    rst_l = 1'b0;
    #2;
    rst_l = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      int r;
      thr_start = rbits(25); thr_stop = rbits(3); switch_out = rbits(12);
      imiss_set = rbits(10); imiss_clr = rbits(30); stb_set = rbits(8); stb_clr = rbits(30);
      mul_issue = rbits(8); mul_done = rbits(30); div_issue = rbits(6); div_done = rbits(30);
      fp_issue = rbits(8); fp_done = rbits(30);
      spec_ok = rbits(50); spec_cfm = rbits(25); spec_kill = rbits(8);
      r = $urandom_range(9);
      if (r < 6) sel_thr = 4'b0001 << $urandom_range(3);
      else if (r < 8) sel_thr = 4'($urandom_range(15));
      else sel_thr = 4'b0000;
      model_next();
      #1;
      checks++;
      if ({mul_wait_nxt, div_wait_nxt, fp_wait_nxt} !== {n_mul, n_div, n_fp}) begin
        errors++;
        $display("FAIL rnd_wait_nxt cyc %0d: got %b %b %b want %b %b %b", cyc,
                 mul_wait_nxt, div_wait_nxt, fp_wait_nxt, n_mul, n_div, n_fp);
      end
      step();
      model_commit();
      for (int t = 0; t < 4; t++) begin
        checks++;
        if (dut_st[t] !== m_st[t]) begin
          errors++;
          $display("FAIL rnd_state cyc %0d t%0d: got %b want %b", cyc, t, dut_st[t], m_st[t]);
        end
      end
      checks++;
      if ({wm_imiss, wm_stbwait, wm_other} !== {m_imiss, m_stb, m_mul | m_div | m_fp}) begin
        errors++;
        $display("FAIL rnd_masks cyc %0d: got %b %b %b want %b %b %b", cyc, wm_imiss,
                 wm_stbwait, wm_other, m_imiss, m_stb, m_mul | m_div | m_fp);
      end
      checks++;
      if ({mul_wait, div_wait, fp_wait} !== {m_mul, m_div, m_fp}) begin
        errors++;
        $display("FAIL rnd_unit_wait cyc %0d: got %b %b %b want %b %b %b", cyc,
                 mul_wait, div_wait, fp_wait, m_mul, m_div, m_fp);
      end
      checks++;
      if (completion !== m_comp) begin
        errors++;
        $display("FAIL rnd_completion cyc %0d: got %b want %b", cyc, completion, m_comp);
      end
      for (int t = 0; t < 4; t++) begin
        checks++;
        if (rdy_vec[t] !== (m_st[t] == S_RDY || m_st[t] == S_SPEC_RDY)) begin
          errors++;
          $display("FAIL rnd_rdy_vec cyc %0d t%0d: got %b want state %b", cyc, t, rdy_vec[t],
                   m_st[t]);
        end
      end
      $display("rnd %0d: start=%b stop=%b sel=%b st=%b %b %b %b comp=%b", cyc, thr_start,
               thr_stop, sel_thr, m_st[0], m_st[1], m_st[2], m_st[3], m_comp);
    end
    clr_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    test_reset();
    test_start();
    test_mul_wait();
    test_overlap();
    test_scheduler();
    test_spec();
    test_stop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
